// File: rtl/data_sram_pkg.sv
// rtl/data_sram_pkg.sv - shared constants, types and byte-merge helper for data_sram_resp
//
// Purpose: MMIO offset map, default MMIO window, response-select type and the
// byte-strobe merge used by both the RAM and the MMIO registers.
package data_sram_pkg;

  localparam logic [15:0] MMIO_HI_DEFAULT = 16'hbfaf;

  localparam logic [15:0] LED_OFS     = 16'h8000;
  localparam logic [15:0] SWITCH_OFS  = 16'h8004;
  localparam logic [15:0] TIMER_OFS   = 16'h8008;
  localparam logic [15:0] SCRATCH_OFS = 16'h800c;

  typedef enum logic {
    SEL_RAM  = 1'b0,
    SEL_MMIO = 1'b1
  } resp_sel_e;

  // Replace only the byte lanes whose strobe is set; other lanes keep old.
  function automatic logic [31:0] bytemerge(input logic [31:0] old,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bw_ram.sv
// rtl/bw_ram.sv - single-port byte-write synchronous RAM, read-first, no reset
//
// Purpose: word-wide storage with per-byte write strobes. A request returns the
// word stored before any write in the same cycle; rdata holds when en=0.
// Ports:
//   clk    in  1       rising-edge clock
//   en     in  1       request valid
//   we     in  4       byte write strobes
//   addr   in  AW      word address
//   wdata  in  32      write data
//   rdata  out 32      registered read data
module bw_ram
  import data_sram_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem[addr];
      if (|we) mem[addr] <= bytemerge(mem[addr], wdata, we);
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data-side SRAM responder: byte-write RAM plus MMIO registers
//
// Purpose: decodes each enabled request to the RAM or the MMIO register file
// (LED, SWITCH, TIMER, SCRATCH) and returns read data one cycle later.
// Ports:
//   clk              in  1   rising-edge clock
//   reset            in  1   asynchronous active-high reset
//   data_sram_en     in  1   request valid
//   data_sram_we     in  4   byte write strobes (nonzero = write)
//   data_sram_addr   in  32  byte address
//   data_sram_wdata  in  32  write data
//   data_sram_rdata  out 32  read data, valid the cycle after the request
//   led              out 16  LED register
//   switch           in  16  board switches
module data_sram_resp
  import data_sram_pkg::*;
#(
  parameter int          RAM_AW  = 12,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [15:0] switch
);

  logic        is_mmio;
  logic        req_wr;
  logic        ram_en;
  logic [15:0] ofs;
  logic [31:0] mmio_rd;
  logic [31:0] led_wide;
  logic [31:0] ram_rdata;

  logic [31:0] mmio_rdata_d, mmio_rdata_q;
  resp_sel_e   sel_d, sel_q;
  logic        vld_d, vld_q;
  logic [15:0] led_d, led_q;
  logic [31:0] timer_d, timer_q;
  logic [31:0] scratch_d, scratch_q;

  // Byte-offset bits and the upper half of the merged LED word carry no state.
  logic unused_ok;
  assign unused_ok = ^{data_sram_addr[1:0], led_wide[31:16]};

  bw_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (data_sram_we),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    is_mmio = (data_sram_addr[31:16] == MMIO_HI);
    ofs     = data_sram_addr[15:0];
    req_wr  = |data_sram_we;
    ram_en  = data_sram_en && !is_mmio;

    // Read mux uses current register values, which gives read-first semantics.
    case (ofs)
      LED_OFS:     mmio_rd = {16'h0000, led_q};
      SWITCH_OFS:  mmio_rd = {16'h0000, switch};
      TIMER_OFS:   mmio_rd = timer_q;
      SCRATCH_OFS: mmio_rd = scratch_q;
      default:     mmio_rd = 32'h0;
    endcase

    led_wide     = bytemerge({16'h0000, led_q}, data_sram_wdata, data_sram_we);
    led_d        = led_q;
    timer_d      = timer_q + 32'd1;
    scratch_d    = scratch_q;
    mmio_rdata_d = mmio_rdata_q;
    sel_d        = sel_q;
    vld_d        = vld_q;

    if (data_sram_en) begin
      vld_d = 1'b1;
      sel_d = is_mmio ? SEL_MMIO : SEL_RAM;
      if (is_mmio) begin
        mmio_rdata_d = mmio_rd;
        if (req_wr) begin
          case (ofs)
            LED_OFS:     led_d     = led_wide[15:0];
            TIMER_OFS:   timer_d   = bytemerge(timer_q, data_sram_wdata, data_sram_we);
            SCRATCH_OFS: scratch_d = bytemerge(scratch_q, data_sram_wdata, data_sram_we);
            default:     ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmio_rdata_q <= 32'h0;
      sel_q        <= SEL_RAM;
      vld_q        <= 1'b0;
      led_q        <= 16'h0;
      timer_q      <= 32'h0;
      scratch_q    <= 32'h0;
    end else begin
      mmio_rdata_q <= mmio_rdata_d;
      sel_q        <= sel_d;
      vld_q        <= vld_d;
      led_q        <= led_d;
      timer_q      <= timer_d;
      scratch_q    <= scratch_d;
    end
  end

  // vld_q masks the unreset RAM output so rdata reads 0 until the first request.
  always_comb begin
    data_sram_rdata = 32'h0;
    if (vld_q) data_sram_rdata = (sel_q == SEL_MMIO) ? mmio_rdata_q : ram_rdata;
  end

  assign led = led_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - directed self-checking bench for data_sram_resp
module tb_data_sram_resp;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [15:0] switch;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] A_LED     = 32'hbfaf8000;
  localparam logic [31:0] A_SWITCH  = 32'hbfaf8004;
  localparam logic [31:0] A_TIMER   = 32'hbfaf8008;
  localparam logic [31:0] A_SCRATCH = 32'hbfaf800c;
  localparam logic [31:0] A_HOLE    = 32'hbfaf8010;

  data_sram_resp dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .switch          (switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Present one request, take the edge, land 1 time unit after it.
  task automatic req(input logic en, input logic [3:0] we,
                     input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
  endtask

  task automatic rd(input logic [31:0] addr);
    req(1'b1, 4'h0, addr, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we);
    req(1'b1, we, addr, wdata);
  endtask

  task automatic idle();
    req(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset           = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    switch          = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    reset = 1'b0;

    repeat (3) idle();
    check("idle_rdata", data_sram_rdata, 32'h0);
    check("idle_led", {16'h0, led}, 32'h0);

    // TIMER read at the first edge after reset release.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    rd(A_TIMER);
    check("timer_first_edge", data_sram_rdata, 32'h0);

    // RAM full write, read back, then single-lane write with read-first.
    wr(32'h00000010, 32'h11223344, 4'hF);
    rd(32'h00000010);
    check("ram_full_wr", data_sram_rdata, 32'h11223344);
    wr(32'h00000010, 32'hAABBCCDD, 4'b0010);
    check("ram_read_first", data_sram_rdata, 32'h11223344);
    rd(32'h00000010);
    check("ram_lane1_wr", data_sram_rdata, 32'h1122CC44);

    // Strobes without enable are ignored; upper address bits alias.
    req(1'b0, 4'hF, 32'h00000010, 32'hFFFFFFFF);
    check("hold_after_idle", data_sram_rdata, 32'h1122CC44);
    rd(32'h00004010);
    check("ram_alias", data_sram_rdata, 32'h1122CC44);

    // Back-to-back reads.
    wr(32'h0, 32'd1, 4'hF);
    wr(32'h4, 32'd2, 4'hF);
    wr(32'h8, 32'd3, 4'hF);
    rd(32'h0);
    check("b2b_0", data_sram_rdata, 32'd1);
    rd(32'h4);
    check("b2b_4", data_sram_rdata, 32'd2);
    rd(32'h8);
    check("b2b_8", data_sram_rdata, 32'd3);

    // LED and SWITCH.
    wr(A_LED, 32'h0001A5A5, 4'hF);
    check("led_wr_prev", data_sram_rdata, 32'h0);
    check("led_out", {16'h0, led}, 32'h0000A5A5);
    rd(A_LED);
    check("led_rd", data_sram_rdata, 32'h0000A5A5);
    switch = 16'h00F0;
    rd(A_SWITCH);
    check("switch_rd", data_sram_rdata, 32'h000000F0);
    wr(A_SWITCH, 32'h12345678, 4'hF);
    switch = 16'h0000;
    rd(A_SWITCH);
    check("switch_ro", data_sram_rdata, 32'h0);
    wr(A_HOLE, 32'h12345678, 4'hF);
    rd(A_HOLE);
    check("hole_rd", data_sram_rdata, 32'h0);
    // RAM access right after MMIO must switch the response source.
    rd(32'h4);
    check("mmio_to_ram", data_sram_rdata, 32'd2);

    // TIMER load and wrap: reads return the pre-increment value.
    wr(A_TIMER, 32'hFFFFFFFE, 4'hF);
    rd(A_TIMER);
    check("timer_loaded", data_sram_rdata, 32'hFFFFFFFE);
    rd(A_TIMER);
    check("timer_inc", data_sram_rdata, 32'hFFFFFFFF);
    rd(A_TIMER);
    check("timer_wrap", data_sram_rdata, 32'h00000000);

    // SCRATCH with async reset in the response cycle.
    wr(A_SCRATCH, 32'hDEADBEEF, 4'hF);
    rd(A_SCRATCH);
    check("scratch_rd", data_sram_rdata, 32'hDEADBEEF);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_rdata", data_sram_rdata, 32'h0);
    check("async_rst_led", {16'h0, led}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(A_SCRATCH);
    check("scratch_after_rst", data_sram_rdata, 32'h0);
    wr(A_SCRATCH, 32'h12345678, 4'b1000);
    rd(A_SCRATCH);
    check("scratch_lane3", data_sram_rdata, 32'h12000000);
    rd(32'h0);
    check("ram_survives_rst", data_sram_rdata, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
